// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding, time record and helpers for the stopwatch slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } sw_state_t;

  localparam int SECONDS_MAX = 59;

  // Packed mm:ss.hh record; field widths match the display ports.
  typedef struct packed {
    logic [5:0] mins;
    logic [5:0] secs;
    logic [6:0] hund;
  } sw_time_t;

  // Saturate a 6-bit preset field at its legal maximum.
  function automatic logic [5:0] clamp6(input logic [5:0] v, input logic [5:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/stopwatch_tick_div.sv
// stopwatch_tick_div: divides the clock down to a one-cycle tick strobe every CLK_HZ/TICK_HZ cycles.
// Latency: first tick lands CLK_HZ/TICK_HZ cycles after the restart cycle.
// Backpressure: none; counting pauses while enable is low.
// Ports: clock/reset_n (async active-low); enable advances the divider; restart forces it to 0
//        synchronously; tick is the strobe output.
module stopwatch_tick_div #(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 100
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  input  logic restart,
  output logic tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  // Reset and restart both land on 0, and DIV >= 2, so no tick can fire
  // in the first cycle after either.
  assign tick = enable && !restart && (cnt == LAST);

endmodule

// File: rtl/stopwatch_core.sv
// stopwatch_core: mm:ss.hh stopwatch / countdown timer with run, pause, preset load and lap freeze.
// Latency: count moves one tick period after start; display registers add one more cycle.
// Backpressure: none; pulses act in their arrival cycle, lower-priority ones in that cycle are dropped.
// Optional feature: STOPWATCH_LAP_EN enables the lap display freeze; without it lap is ignored.
// Ports: clock, reset_n (async active-low); start_stop, clear, lap, load one-cycle pulses;
//        mode (0 up, 1 down, sampled in IDLE); load_minutes/load_seconds preset;
//        minutes/seconds/hundredths registered display; running/expired registered status.
module stopwatch_core #(
  parameter int CLK_HZ      = 50000000,
  parameter int TICK_HZ     = 100,
  parameter int MAX_MINUTES = 59
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  input  logic       mode,
  input  logic       load,
  input  logic [5:0] load_minutes,
  input  logic [5:0] load_seconds,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [6:0] hundredths,
  output logic       running,
  output logic       expired
);

  import stopwatch_pkg::*;

  localparam logic [6:0] HUND_LAST = 7'(TICK_HZ - 1);
  localparam logic [5:0] SEC_LAST  = 6'(SECONDS_MAX);
  localparam logic [5:0] MIN_LAST  = 6'(MAX_MINUTES);

  sw_state_t state_q, state_d;
  sw_time_t  cnt_q, cnt_d, cnt_step, disp_q;
  logic      mode_q, down, tick, is_zero, step_zero;
  logic      freeze_q, freeze_d, hold_disp;
  logic      running_d, expired_d, running_q, expired_q;
  logic      div_en, div_restart;

  function automatic sw_time_t time_inc(input sw_time_t t);
    sw_time_t r;
    r = t;
    if (t.hund != HUND_LAST) begin
      r.hund = t.hund + 7'd1;
    end else begin
      r.hund = '0;
      if (t.secs != SEC_LAST) begin
        r.secs = t.secs + 6'd1;
      end else begin
        r.secs = '0;
        r.mins = (t.mins != MIN_LAST) ? t.mins + 6'd1 : 6'd0;
      end
    end
    return r;
  endfunction

  function automatic sw_time_t time_dec(input sw_time_t t);
    sw_time_t r;
    r = t;
    if (t.hund != 7'd0) begin
      r.hund = t.hund - 7'd1;
    end else begin
      r.hund = HUND_LAST;
      if (t.secs != 6'd0) begin
        r.secs = t.secs - 6'd1;
      end else begin
        r.secs = SEC_LAST;
        r.mins = (t.mins != 6'd0) ? t.mins - 6'd1 : MIN_LAST;
      end
    end
    return r;
  endfunction

  stopwatch_tick_div #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_tick_div (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (div_en),
    .restart (div_restart),
    .tick    (tick)
  );

  // Direction follows the live mode pin while idle, and the value latched
  // on leaving IDLE everywhere else.
  assign down      = (state_q == IDLE) ? mode : mode_q;
  assign cnt_step  = down ? time_dec(cnt_q) : time_inc(cnt_q);
  assign is_zero   = (cnt_q == '0);
  assign step_zero = (cnt_step == '0);

  // FSM: state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state. Expiry is not a pulse, so only clear can override it.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else if (tick && down && step_zero) begin
      state_d = EXPIRED;
    end else if (!load && start_stop) begin
      case (state_q)
        IDLE, PAUSE: state_d = (down && is_zero) ? EXPIRED : RUN;
        RUN:         state_d = PAUSE;
        default:     state_d = state_q;
      endcase
    end
  end

  // FSM: outputs. Status is computed from the next state so the registered
  // running/expired flags line up with the state register.
  always_comb begin
    running_d   = (state_d == RUN);
    expired_d   = (state_d == EXPIRED);
    div_en      = (state_q == RUN);
    div_restart = (state_d == RUN) && (state_q != RUN);
  end

  // Count and freeze next-state
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (load && (state_q == IDLE || state_q == PAUSE)) begin
      cnt_d = '{mins: clamp6(load_minutes, MIN_LAST),
                secs: clamp6(load_seconds, SEC_LAST),
                hund: 7'd0};
    end else if (tick) begin
      cnt_d = cnt_step;
    end

`ifdef STOPWATCH_LAP_EN
    if (clear) begin
      freeze_d = 1'b0;
    end else if (lap && !load && !start_stop) begin
      freeze_d = !freeze_q;
    end else begin
      freeze_d = freeze_q;
    end
`else
    freeze_d = lap & 1'b0;  // lap has no effect in this build
`endif
  end

  // Display holds only while frozen both before and after this edge: the lap
  // edge itself captures the count, and the unfreezing edge resumes tracking.
  assign hold_disp = freeze_q && freeze_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      disp_q    <= '0;
      mode_q    <= 1'b0;
      freeze_q  <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      freeze_q  <= freeze_d;
      running_q <= running_d;
      expired_q <= expired_d;
      if (state_q == IDLE) begin
        mode_q <= mode;
      end
      if (!hold_disp) begin
        disp_q <= cnt_q;
      end
    end
  end

  assign minutes    = disp_q.mins;
  assign seconds    = disp_q.secs;
  assign hundredths = disp_q.hund;
  assign running    = running_q;
  assign expired    = expired_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: directed scenarios plus random pulses against a total-hundredths reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_stopwatch_core;

  localparam int CLK_HZ = 1000;
  localparam int TICK_HZ = 100;
  localparam int MAXM = 1;
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int TPM = 60 * TICK_HZ;
  localparam int WRAP = (MAXM + 1) * TPM;

  localparam int S_IDLE = 0;
  localparam int S_RUN = 1;
  localparam int S_PAUSE = 2;
  localparam int S_EXP = 3;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic       lap = 1'b0;
  logic       mode = 1'b0;
  logic       load = 1'b0;
  logic [5:0] load_minutes = 6'd0;
  logic [5:0] load_seconds = 6'd0;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [6:0] hundredths;
  logic       running;
  logic       expired;

  int total = 0;
  int bad = 0;

  // Reference model: time kept as a single count of hundredths.
  int m_state, m_total, m_disp, m_edge, m_run_edge;
  bit m_freeze, m_latched;

  stopwatch_core #(
    .CLK_HZ      (CLK_HZ),
    .TICK_HZ     (TICK_HZ),
    .MAX_MINUTES (MAXM)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start_stop   (start_stop),
    .clear        (clear),
    .lap          (lap),
    .mode         (mode),
    .load         (load),
    .load_minutes (load_minutes),
    .load_seconds (load_seconds),
    .minutes      (minutes),
    .seconds      (seconds),
    .hundredths   (hundredths),
    .running      (running),
    .expired      (expired)
  );

  always #5 clock = ~clock;

  function automatic logic [20:0] obs();
    return {minutes, seconds, hundredths, running, expired};
  endfunction

  function automatic logic [20:0] pack(input int mm, input int ss, input int hh, input bit r, input bit e);
    return {6'(mm), 6'(ss), 7'(hh), r, e};
  endfunction

  function automatic logic [20:0] model_pack();
    return pack(m_disp / TPM, (m_disp / TICK_HZ) % 60, m_disp % TICK_HZ,
                m_state == S_RUN, m_state == S_EXP);
  endfunction

  task automatic check(input string tag, input logic [20:0] o, input logic [20:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic model_reset();
    m_state = S_IDLE; m_total = 0; m_disp = 0; m_freeze = 0; m_latched = 0; m_run_edge = 0;
  endtask

  // Called just after a rising edge, while the inputs still hold the values sampled there.
  task automatic model_edge();
    int  old_total;
    bit  old_freeze, dn, tk, exp_now;
    int  lm, ls;
    old_total  = m_total;
    old_freeze = m_freeze;
    exp_now    = 0;
    m_edge++;
    dn = (m_state == S_IDLE) ? mode : m_latched;
    tk = (m_state == S_RUN) && ((m_edge - m_run_edge) % DIV == 0);
    if (m_state == S_IDLE) m_latched = mode;
    if (clear) begin
      m_state = S_IDLE; m_total = 0; m_freeze = 0;
    end else begin
      if (tk) begin
        if (dn) begin
          m_total = m_total - 1;
          exp_now = (m_total == 0);
        end else begin
          m_total = (m_total + 1) % WRAP;
        end
      end
      if (load) begin
        if (m_state == S_IDLE || m_state == S_PAUSE) begin
          lm = (load_minutes > MAXM) ? MAXM : int'(load_minutes);
          ls = (load_seconds > 59) ? 59 : int'(load_seconds);
          m_total = lm * TPM + ls * TICK_HZ;
        end
      end else if (start_stop) begin
        if (m_state == S_IDLE || m_state == S_PAUSE) begin
          if (dn && m_total == 0) m_state = S_EXP;
          else begin m_state = S_RUN; m_run_edge = m_edge; end
        end else if (m_state == S_RUN) begin
          m_state = S_PAUSE;
        end
      end else if (lap) begin
`ifdef STOPWATCH_LAP_EN
        m_freeze = !m_freeze;
`endif
      end
      if (exp_now) m_state = S_EXP;
    end
    if (!(old_freeze && m_freeze)) m_disp = old_total;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      model_edge();
      #1;
      start_stop = 1'b0; clear = 1'b0; lap = 1'b0; load = 1'b0;
    end
  endtask

  initial begin
    m_edge = 0;
    model_reset();

    // Reset held 20 cycles, released between edges.
    repeat (20) @(posedge clock);
    #3 reset_n = 1'b1;
    check("reset_state", obs(), pack(0, 0, 0, 0, 0));

    // First tick lands DIV cycles after start; display lags by one.
    start_stop = 1'b1; step(1);
    step(10);
    check("first_tick_internal", obs(), pack(0, 0, 0, 1, 0));
    step(1);
    check("first_tick_display", obs(), pack(0, 0, 1, 1, 0));
    step(989); step(1);
    check("up_1000_cycles", obs(), pack(0, 1, 0, 1, 0));
    check("up_1000_model", obs(), model_pack());

    // clear beats start_stop in the same cycle.
    clear = 1'b1; start_stop = 1'b1; step(1); step(1);
    check("clear_over_start", obs(), pack(0, 0, 0, 0, 0));

    // Preset 63:63 clamps to 01:59, then wraps past 01:59.99.
    load_minutes = 6'd63; load_seconds = 6'd63; load = 1'b1; step(1); step(1);
    check("load_clamp", obs(), pack(1, 59, 0, 0, 0));
    start_stop = 1'b1; step(1);
    step(990); step(10);
    check("pre_wrap", obs(), pack(1, 59, 99, 1, 0));
    step(1);
    check("wrap_to_zero", obs(), pack(0, 0, 0, 1, 0));
    check("wrap_model", obs(), model_pack());

    // Countdown from 00:01.00 expires and then ignores start_stop.
    clear = 1'b1; step(1);
    mode = 1'b1; load_minutes = 6'd0; load_seconds = 6'd1; load = 1'b1; step(1);
    start_stop = 1'b1; step(1);
    step(1000); step(1);
    check("down_expired", obs(), pack(0, 0, 0, 0, 1));
    start_stop = 1'b1; step(2);
    check("expired_ignores_start", obs(), pack(0, 0, 0, 0, 1));

    // Start in down mode at zero expires at once.
    clear = 1'b1; step(2);
    start_stop = 1'b1; step(1);
    check("start_zero_down", obs(), pack(0, 0, 0, 0, 1));

    // Lap freeze and release.
    clear = 1'b1; mode = 1'b0; step(2);
    start_stop = 1'b1; step(1);
    step(50);
    lap = 1'b1; step(1);
    step(50);
`ifdef STOPWATCH_LAP_EN
    check("lap_frozen", obs(), pack(0, 0, 5, 1, 0));
`else
    check("lap_ignored", obs(), pack(0, 0, 10, 1, 0));
`endif
    lap = 1'b1; step(1);
    check("lap_released", obs(), pack(0, 0, 10, 1, 0));
    check("lap_model", obs(), model_pack());

    // Asynchronous reset mid-run clears outputs before the next edge.
    step(30);
    #2 reset_n = 1'b0;
    model_reset();
    #1 check("async_reset", obs(), pack(0, 0, 0, 0, 0));
    @(posedge clock);
    #3 reset_n = 1'b1;
    check("reset_release", obs(), pack(0, 0, 0, 0, 0));
    step(3);
    check("after_release_model", obs(), model_pack());

    // Random pulses against the model.
    for (int c = 0; c < 3000; c++) begin
      if (c % 40 == 0) mode = 1'($urandom_range(0, 1));
      clear        = ($urandom_range(0, 99) < 2);
      load         = ($urandom_range(0, 99) < 4);
      start_stop   = ($urandom_range(0, 99) < 3);
      lap          = ($urandom_range(0, 99) < 4);
      load_minutes = 6'($urandom_range(0, 63));
      load_seconds = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 1)) : 6'($urandom_range(0, 63));
      step(1);
      check($sformatf("random_c%0d", c), obs(), model_pack());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
